// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the burst-capable on-chip memory slave.
package onchip_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } burst_state_e;

  localparam int unsigned MAX_READ_LATENCY = 32'd3;
  localparam int unsigned MIN_READ_LATENCY = 32'd1;

  // A burstcount of zero behaves as a single beat.
  function automatic int unsigned burst_len(input int unsigned burstcount);
    return (burstcount == 32'd0) ? 32'd1 : burstcount;
  endfunction

endpackage

// File: rtl/onchip_memory_burst_if.sv
// Avalon-MM burst slave bus bundle shared by the memory and its master.
interface onchip_memory_burst_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 13,
  parameter int BURST_WIDTH = 4
) ();

  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [BURST_WIDTH-1:0]  burstcount;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_ram_be.sv
// Inferred single-port RAM with byte-lane writes and a one-cycle registered read
// that returns the old word on a same-address read-during-write.
module onchip_mem_ram_be #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 13,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array storage carries no reset so it maps onto block RAM.
  always @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/onchip_memory_burst_chk.sv
// Protocol assertions for the burst memory slave: configuration range and
// master misuse that the slave resolves silently.
module onchip_memory_burst_chk
  import onchip_mem_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic reset_n,
  input logic clken,
  input logic chipselect,
  input logic read,
  input logic write,
  input logic waitrequest,
  input logic in_wr_burst
);

  localparam bit LAT_OK = (READ_LATENCY >= int'(MIN_READ_LATENCY)) &&
                          (READ_LATENCY <= int'(MAX_READ_LATENCY));

  always @(posedge clk) begin
    if (reset_n && clken) begin
      assert (LAT_OK) else $error("READ_LATENCY outside legal range");
      assert (!(chipselect && read && write && !waitrequest))
        else $error("read and write asserted together, write taken");
      assert (!(in_wr_burst && chipselect && read))
        else $error("read during open write burst ignored");
    end
  end

endmodule

// File: rtl/onchip_memory_burst.sv
// Avalon-MM burst memory slave: read/write bursts, pipelined reads with
// readdatavalid, waitrequest back-pressure and a clock-enable stall.
module onchip_memory_burst
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 13,
  parameter int    READ_LATENCY = 2,
  parameter int    BURST_WIDTH  = 4,
  parameter string INIT_FILE    = "onchip_memory_burst.hex"
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic                  clken,
  onchip_memory_burst_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_WIDTH-1:0] REM_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_WIDTH-1:0] REM_ZERO = {BURST_WIDTH{1'b0}};

  burst_state_e            state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BURST_WIDTH-1:0]  remaining_q;
  logic                    wait_q;
  logic [READ_LATENCY-1:0] valid_q;
  logic [READ_LATENCY-1:0] valid_d;

  logic                    cmd_ok_s;
  logic                    wr_first_s;
  logic                    rd_first_s;
  logic                    wr_beat_s;
  logic                    rd_issue_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_s;
  logic [BURST_WIDTH-1:0]  first_remaining_s;
  logic                    more_beats_s;
  logic [DATA_WIDTH-1:0]   ram_rdata_s;
  logic [DATA_WIDTH-1:0]   readdata_s;

  // Command decode: write wins over read; bursts use the latched running address.
  always_comb begin
    cmd_ok_s          = bus.chipselect & (bus.read | bus.write) & ~wait_q & clken;
    first_remaining_s = BURST_WIDTH'(burst_len(32'(bus.burstcount)) - 32'd1);
    more_beats_s      = (first_remaining_s != REM_ZERO);
    wr_first_s        = 1'b0;
    rd_first_s        = 1'b0;
    wr_beat_s         = 1'b0;
    rd_issue_s        = 1'b0;
    ram_addr_s        = addr_q;
    case (state_q)
      IDLE: begin
        ram_addr_s = bus.address;
        wr_first_s = cmd_ok_s & bus.write;
        rd_first_s = cmd_ok_s & ~bus.write;
        wr_beat_s  = cmd_ok_s & bus.write;
        rd_issue_s = cmd_ok_s & ~bus.write;
      end
      RD_BURST: begin
        rd_issue_s = clken;
      end
      WR_BURST: begin
        wr_beat_s = cmd_ok_s & bus.write;
      end
      default: begin
        ram_addr_s = addr_q;
      end
    endcase
  end

  // Burst sequencer; addr_q always holds the address of the next beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wait_q      <= 1'b1;
    end else if (clken) begin
      case (state_q)
        IDLE: begin
          wait_q <= 1'b0;
          if (wr_first_s || rd_first_s) begin
            addr_q      <= bus.address + ADDR_ONE;
            remaining_q <= first_remaining_s;
            if (more_beats_s) begin
              state_q <= wr_first_s ? WR_BURST : RD_BURST;
              wait_q  <= rd_first_s;
            end
          end
        end
        RD_BURST: begin
          addr_q      <= addr_q + ADDR_ONE;
          remaining_q <= remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
          end
        end
        WR_BURST: begin
          if (wr_beat_s) begin
            addr_q      <= addr_q + ADDR_ONE;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end

  onchip_mem_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (wr_beat_s),
    .re_i    (rd_issue_s),
    .addr_i  (ram_addr_s),
    .be_i    (bus.byteenable),
    .wdata_i (bus.writedata),
    .rdata_o (ram_rdata_s)
  );

  // Valid shift register; bit 0 marks a word sitting in the RAM output register.
  always_comb begin
    valid_d    = valid_q;
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      valid_d[i] = valid_q[i-1];
    end
    valid_d[0] = rd_issue_s;
  end

  // Latency pipeline freezes with clken so nothing is lost or duplicated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clken) begin
      valid_q <= valid_d;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign readdata_s = ram_rdata_s;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] dpipe_q [READ_LATENCY-1];

    // Stages load only alongside a valid so readdata holds between beats.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          dpipe_q[i] <= '0;
        end
      end else if (clken) begin
        if (valid_q[0]) begin
          dpipe_q[0] <= ram_rdata_s;
        end
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          if (valid_q[i]) begin
            dpipe_q[i] <= dpipe_q[i-1];
          end
        end
      end
    end

    assign readdata_s = dpipe_q[READ_LATENCY-2];
  end

  assign bus.readdata      = readdata_s;
  assign bus.readdatavalid = valid_q[READ_LATENCY-1] & clken;
  assign bus.waitrequest   = wait_q | ~clken;

  onchip_memory_burst_chk #(
    .READ_LATENCY (READ_LATENCY)
  ) u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .clken       (clken),
    .chipselect  (bus.chipselect),
    .read        (bus.read),
    .write       (bus.write),
    .waitrequest (bus.waitrequest),
    .in_wr_burst (state_q == WR_BURST)
  );

endmodule

// File: tb/tb_onchip_memory_burst.sv
// Directed plus randomized bench for onchip_memory_burst against an array/queue model.
module tb_onchip_memory_burst;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic clken   = 1'b1;

  onchip_memory_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .BURST_WIDTH(4)) bus ();

  onchip_memory_burst #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (13),
    .READ_LATENCY (2),
    .BURST_WIDTH  (4),
    .INIT_FILE    ("")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  logic [31:0] mem_m [8192];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read monitor: in-order scoreboard, and no valid may appear with nothing outstanding.
  always @(negedge clk) begin
    #2;
    if (exp_q.size() == 0) begin
      check("idle_rdv", {31'd0, bus.readdatavalid}, 32'd0);
    end else if (bus.readdatavalid === 1'b1) begin
      check("rdata", bus.readdata, exp_q.pop_front());
      rd_cnt++;
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    #1;
    while (bus.waitrequest !== 1'b0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, bus.waitrequest}, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // mode 0: random data, 1: data = word address, 2: fixed data
  task automatic wr_burst(input logic [12:0] addr, input logic [3:0] bc, input logic [3:0] be,
                          input int gap_at, input int mode, input logic [31:0] fixed);
    int beats = (bc == 4'd0) ? 1 : int'(bc);
    logic [31:0] d;
    logic [12:0] a;
    for (int k = 0; k < beats; k++) begin
      @(negedge clk);
      if (k == gap_at) begin
        bus.write = 1'b0;
        #1;
        check("wgap_wait", {31'd0, bus.waitrequest}, 32'd0);
        @(negedge clk);
      end
      a = addr + 13'(k);
      d = (mode == 1) ? {19'd0, a} : (mode == 2) ? fixed : $urandom;
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.read       = 1'b0;
      bus.address    = (k == 0) ? addr : 13'($urandom);
      bus.burstcount = (k == 0) ? bc : 4'($urandom);
      bus.byteenable = be;
      bus.writedata  = d;
      if (k == 0) begin
        wait_ready("wr_ready");
      end else begin
        #1;
        check("wburst_wait", {31'd0, bus.waitrequest}, 32'd0);
      end
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  // Returns on the falling edge right after the command edge.
  task automatic rd_burst(input logic [12:0] addr, input logic [3:0] bc);
    int beats = (bc == 4'd0) ? 1 : int'(bc);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = addr;
    bus.burstcount = bc;
    bus.byteenable = 4'hF;
    wait_ready("rd_ready");
    for (int k = 0; k < beats; k++) exp_q.push_back(mem_m[addr + 13'(k)]);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_hi, v_cnt, first, last, start, n;
    logic [12:0] a;
    logic [3:0]  bc;

    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = 13'd0; bus.byteenable = 4'hF; bus.writedata = 32'd0; bus.burstcount = 4'd1;
    for (int i = 0; i < 8192; i++) mem_m[i] = 32'd0;

    // reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_wait", {31'd0, bus.waitrequest}, 32'd1);
    check("rst_rdv", {31'd0, bus.readdatavalid}, 32'd0);
    check("rst_rdata", bus.readdata, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel_wait_hi", {31'd0, bus.waitrequest}, 32'd1);
    @(negedge clk);
    #1 check("rel_wait_lo", {31'd0, bus.waitrequest}, 32'd0);

    // single write / read with latency check
    wr_burst(13'h010, 4'd1, 4'hF, -1, 2, 32'hDEADBEEF);
    rd_burst(13'h010, 4'd1);
    #2 check("lat_early", {31'd0, bus.readdatavalid}, 32'd0);
    @(negedge clk);
    #2 check("lat_exact", {31'd0, bus.readdatavalid}, 32'd1);
    check("lat_data", bus.readdata, 32'hDEADBEEF);
    wait_drain();

    // byte-lane merge
    wr_burst(13'h020, 4'd1, 4'hF, -1, 2, 32'h11223344);
    wr_burst(13'h020, 4'd1, 4'b0101, -1, 2, 32'hAABBCCDD);
    rd_burst(13'h020, 4'd1);
    @(negedge clk);
    #1 check("be_merge", bus.readdata, 32'h11BB33DD);
    wait_drain();

    // wrapping 8-beat read burst
    wr_burst(13'h1FFC, 4'd8, 4'hF, -1, 1, 32'd0);
    rd_burst(13'h1FFC, 4'd8);
    wr_hi = 0; v_cnt = 0; first = -1; last = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      if (bus.waitrequest === 1'b1) wr_hi++;
      if (bus.readdatavalid === 1'b1) begin
        v_cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("rb_wait_cycles", 32'(wr_hi), 32'd7);
    check("rb_valid_cnt", 32'(v_cnt), 32'd8);
    check("rb_first", 32'(first), 32'd2);
    check("rb_last", 32'(last), 32'd9);
    wait_drain();

    // write burst with idle cycle between beats 2 and 3
    wr_burst(13'h100, 4'd4, 4'hF, 2, 0, 32'd0);
    rd_burst(13'h100, 4'd4);
    wait_drain();

    // clken stall during a read burst
    rd_burst(13'h1FFE, 4'd4);
    start = rd_cnt;
    @(negedge clk);
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_wait", {31'd0, bus.waitrequest}, 32'd1);
      check("stall_rdv", {31'd0, bus.readdatavalid}, 32'd0);
      @(negedge clk);
    end
    clken = 1'b1;
    wait_drain();
    check("stall_cnt", 32'(rd_cnt - start), 32'd4);

    // reset in the middle of an 8-beat read burst
    rd_burst(13'h1FFC, 4'd8);
    start = rd_cnt;
    n = 0;
    while ((rd_cnt - start) < 3 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("pre_reset_cnt", 32'(rd_cnt - start), 32'd3);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_rdv", {31'd0, bus.readdatavalid}, 32'd0);
    check("mrst_rdata", bus.readdata, 32'd0);
    check("mrst_wait", {31'd0, bus.waitrequest}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    rd_burst(13'h1FFD, 4'd1);
    wait_drain();

    // randomized bursts, including burstcount 0 and address wrap
    repeat (6) begin
      a  = 13'($urandom);
      bc = 4'($urandom_range(0, 8));
      wr_burst(a, bc, 4'hF, int'($urandom_range(1, 3)), 0, 32'd0);
      wr_burst(a, 4'd1, 4'($urandom), -1, 0, 32'd0);
      rd_burst(a, bc);
      wait_drain();
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
